serial_cla_subtractor: RTL and testbench
========================================

SERIAL_CLA_SUBTRACTOR -- requirements
Module: serial_cla_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port in_valid  input  1  operands a, b, bin are valid this cycle.
REQ-005 Port in_ready  output  1  block can accept an operation this cycle.
REQ-006 Port a  input  WIDTH  minuend, unsigned.
REQ-007 Port b  input  WIDTH  subtrahend, unsigned.
REQ-008 Port bin  input  1  borrow in.
REQ-009 Port out_valid  output  1  diff and bout are valid.
REQ-010 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-012 Port bout  output  1  borrow out; 1 when a < b + bin as unsigned values.

Function
REQ-013 The block SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 Subtraction SHALL be computed as a + ~b + carry, with the carry initialised to ~bin.
REQ-015 Each RUN cycle SHALL process one 4-bit nibble, LSB nibble first, using lookahead equations.
- g = a & ~b; p = a ^ ~b.
- c1..c4 are expanded from g, p and the carry (no ripple).
REQ-016 Each RUN cycle SHALL write its nibble of diff and register c4 as the carry for the next nibble.
REQ-017 in_ready SHALL equal (state == IDLE), decoded from registered state only.
REQ-018 in_valid SHALL be ignored in RUN and DONE.
REQ-019 IDLE with in_valid=1 SHALL, on the clock edge:
- capture a, b and ~bin;
- clear the nibble index;
- enter RUN.
REQ-020 RUN SHALL last exactly N = WIDTH/4 cycles, then enter DONE.
- For an acceptance edge k, out_valid SHALL rise after edge k+N.
REQ-021 On leaving RUN, bout SHALL be set to the inverse of the final carry.
REQ-022 out_valid SHALL equal (state == DONE).
- diff and bout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 DONE with out_ready=1 SHALL enter IDLE on the edge; no accept occurs in that same cycle.
- Minimum issue interval is N+2 cycles.
REQ-024 out_ready SHALL be ignored in IDLE and RUN.
REQ-025 The diff nibbles not yet processed during RUN are don't-care.
- Only the values at out_valid=1 are architectural.

Reset
REQ-026 rst_n=0 SHALL immediately force, regardless of clk:
- state to IDLE;
- diff, bout and the carry to 0;
- the nibble index to 0;
- out_valid to 0 and in_ready to 1.
REQ-027 Reset during RUN or DONE SHALL discard the operation with no result delivered.
- The first accept after rst_n deasserts SHALL behave as if from power-up.

Configuration
REQ-028 Macro SUB_OVF_EN defined: output port ovf (1 bit), registered with bout.
- ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
- This is signed two's-complement overflow.
- ovf resets to 0 and follows the REQ-022 hold rules.
REQ-029 Macro SUB_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=16, N=4)
REQ-030 a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0; out_valid rises exactly 4 edges after acceptance.
REQ-031 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
REQ-032 Carry across all nibbles: a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> diff, bout, out_valid held and in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Protocol and reset:
- in_valid held high through RUN with changing a -> result unaffected;
- rst_n pulsed low in the 2nd RUN cycle -> outputs 0 and IDLE at once;
- next op 0x0003-0x0001 -> diff=0x0002.
REQ-035 SUB_OVF_EN defined:
- 0x8000-0x0001 -> diff=0x7FFF, ovf=1;
- 0x7FFF-0xFFFF -> diff=0x8000, ovf=1, bout=1;
- 0x0005-0x0003 -> ovf=0.

Source files
------------

// File: rtl/serial_cla_subtractor.sv
// Serial subtractor: computes a - b - bin one 4-bit nibble per cycle using
// carry-lookahead equations on a + ~b + ~bin, LSB nibble first.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_cla_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic            carry_q, carry_d;
    logic            bout_q, bout_d;
    logic [IdxW-1:0] idx_q, idx_d;
`ifdef SUB_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic [3:0] a_nib, nb_nib, g, p, sum;
    logic [4:0] c;

    // Lookahead adder for the current nibble of a + ~b with the registered carry
    always_comb begin
        a_nib  = a_q[{idx_q, 2'b00} +: 4];
        nb_nib = ~b_q[{idx_q, 2'b00} +: 4];
        g      = a_nib & nb_nib;
        p      = a_nib ^ nb_nib;
        c[0]   = carry_q;
        c[1]   = g[0] | (p[0] & c[0]);
        c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (&p & c[0]);
        sum    = p ^ c[3:0];
    end

    // Next-state logic: accept in IDLE, one nibble per RUN cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        idx_d   = idx_q;
`ifdef SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~bin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                diff_d[{idx_q, 2'b00} +: 4] = sum;
                carry_d = c[4];
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    // Carry out of a + ~b + ~bin is the inverse of the borrow
                    bout_d  = ~c[4];
`ifdef SUB_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[3] ^ a_q[WIDTH-1]);
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            idx_q   <= idx_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake outputs decode registered state only
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        diff      = diff_q;
        bout      = bout_q;
`ifdef SUB_OVF_EN
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Bench for serial_cla_subtractor (WIDTH=16): directed cases plus random
// operations checked against an integer-arithmetic reference model.
module tb_serial_cla_subtractor;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    serial_cla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
`ifdef SUB_OVF_EN
        .ovf      (ovf),
`endif
        .bout     (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: a - b - bin, borrow when the true result is negative
    function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                                  output logic [15:0] d, output logic bo, output logic ov);
        int signed r;
        r  = int'(av) - int'(bv) - int'(bi);
        d  = r[15:0];
        bo = (r < 0);
        ov = (av[15] != bv[15]) && (d[15] != av[15]);
    endfunction

    // One complete operation: accept, count latency, check result, hold, release
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                          input int hold, input bit wiggle, input string tag);
        logic [15:0] ed;
        logic        eb;
        logic        eo;
        int          edges;
        model(av, bv, bi, ed, eb, eo);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(posedge clk);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wiggle) begin
                a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
                out_ready = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) break;
            @(posedge clk);
            edges++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, ".latency"}, edges, N);
        chk({tag, ".diff"}, {16'd0, diff}, {16'd0, ed});
        chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SUB_OVF_EN
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`endif
        chk({tag, ".in_ready_done"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ".hold_diff"}, {16'd0, diff}, {16'd0, ed});
            chk({tag, ".hold_bout"}, {31'd0, bout}, {31'd0, eb});
            chk({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".release_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".release_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #12;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.diff", {16'd0, diff}, 32'd0);
        chk("reset.bout", {31'd0, bout}, 32'd0);
`ifdef SUB_OVF_EN
        chk("reset.ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, "basic");
        run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, "underflow");
        run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0, "bin_borrow");
        run_op(16'h1000, 16'h0001, 1'b0, 0, 1'b0, "carry_chain");
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, "max_bin");
        run_op(16'hBEEF, 16'h1234, 1'b1, 10, 1'b0, "backpressure");
        run_op(16'h5A5A, 16'h1111, 1'b0, 2, 1'b1, "in_valid_held");

        // Reset in the second RUN cycle discards the operation
        @(negedge clk);
        a = 16'h4321; b = 16'h0101; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_reset.diff", {16'd0, diff}, 32'd0);
        chk("mid_reset.bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_reset.no_result", {31'd0, out_valid}, 32'd0);
        run_op(16'h0003, 16'h0001, 1'b0, 0, 1'b0, "post_reset");

`ifdef SUB_OVF_EN
        run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, "ovf_neg");
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0, "ovf_pos");
        run_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0, "ovf_none");
`endif

        for (int k = 0; k < 24; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
